// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl: turns a single-port synchronous-read RAM into a streaming
// FIFO with valid/ready push and pop interfaces.
// One RAM access per cycle. A write wins over a read unless the output side
// is completely dry, which keeps the consumer from being starved by writes.
// A 2-entry output buffer absorbs the one-cycle RAM read latency.
// Optional build macro: SPRAM_FIFO_WATERMARK_EN adds wm_clr / max_count.
module spram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH:0]   count
`ifdef SPRAM_FIFO_WATERMARK_EN
    ,
    input  logic                  wm_clr,
    output logic [ADDR_WIDTH:0]   max_count
`endif
);

    // RAM occupancy value meaning "every address holds a live word"
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
    logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;

    logic [1:0]            occ;
    logic [1:0]            occ_after_pop;
    logic                  pop_now;
    logic                  ram_has_data;
    logic                  rd_ok;
    logic                  rd_pri;
    logic                  wr_en;
    logic                  rd_en;

    // Output-side occupancy and the read/write arbitration for this cycle
    always_comb begin
        out_valid     = (obuf_cnt_q != 2'd0);
        out_data      = obuf0_q;
        pop_now       = out_valid && out_ready;
        occ           = obuf_cnt_q + {1'b0, rd_inflight_q};
        occ_after_pop = occ - {1'b0, pop_now};
        ram_has_data  = (ram_cnt_q != '0);
        rd_ok         = ram_has_data && (occ_after_pop < 2'd2);
        rd_pri        = ram_has_data && (occ == 2'd0);
        in_ready      = !rst && (ram_cnt_q != FULL_CNT) && !rd_pri;
        wr_en         = in_valid && in_ready;
        rd_en         = !rst && !wr_en && rd_ok;
        ram_we        = wr_en;
        ram_addr      = wr_en ? wr_ptr_q : rd_ptr_q;
        ram_din       = in_data;
        count         = ram_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, occ};
    end

    // Next-state for pointers, RAM occupancy and the output buffer
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ram_cnt_d     = ram_cnt_q;
        rd_inflight_d = rd_en;
        obuf0_d       = obuf0_q;
        obuf1_d       = obuf1_q;
        obuf_cnt_d    = obuf_cnt_q;

        if (wr_en) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q + 1'b1;
        end else if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q - 1'b1;
        end

        // Pop shifts first, then the returning read word lands in the first
        // free slot, so a same-edge pop and capture keeps order intact.
        if (pop_now) begin
            obuf0_d    = obuf1_q;
            obuf_cnt_d = obuf_cnt_q - 2'd1;
        end
        if (rd_inflight_q) begin
            if (obuf_cnt_d == 2'd0) begin
                obuf0_d = ram_dout;
            end else begin
                obuf1_d = ram_dout;
            end
            obuf_cnt_d = obuf_cnt_d + 2'd1;
        end
    end

    // State registers, cleared asynchronously; RAM contents are left alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            obuf0_q       <= '0;
            obuf1_q       <= '0;
            obuf_cnt_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            obuf0_q       <= obuf0_d;
            obuf1_q       <= obuf1_d;
            obuf_cnt_q    <= obuf_cnt_d;
        end
    end

`ifdef SPRAM_FIFO_WATERMARK_EN
    logic [ADDR_WIDTH:0] max_count_q, max_count_d;

    // Peak tracker; a clear reloads it with the present occupancy
    always_comb begin
        max_count_d = max_count_q;
        if (wm_clr) begin
            max_count_d = count;
        end else if (count > max_count_q) begin
            max_count_d = count;
        end
    end

    // Peak register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_count_q <= '0;
        end else begin
            max_count_q <= max_count_d;
        end
    end

    assign max_count = max_count_q;
`endif

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl (ADDR_WIDTH=3): queue-based reference model
// checked every cycle, a behavioural RAM, and directed scenarios.
module tb_spram_fifo_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [AW:0]   count;
`ifdef SPRAM_FIFO_WATERMARK_EN
    logic          wm_clr;
    logic [AW:0]   max_count;
`endif

    int checks;
    int failures;

    spram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .count     (count)
`ifdef SPRAM_FIFO_WATERMARK_EN
        ,
        .wm_clr    (wm_clr),
        .max_count (max_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous-read RAM
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words in RAM, word in flight, output buffer
    int m_ram[$];
    int m_obuf[$];
    bit m_inf;
    int m_inf_data;
    int m_wp;
    int m_rp;
    int got[$];

    always @(negedge clk) begin : compare
        int  occ;
        bit  pop;
        bit  rdpri;
        bit  e_ir;
        bit  push;
        bit  rd;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_count", count, 0);
            chk("rst_ram_addr", ram_addr, 0);
            m_ram.delete();
            m_obuf.delete();
            m_inf = 0;
            m_wp  = 0;
            m_rp  = 0;
        end else begin
            occ   = m_obuf.size() + int'(m_inf);
            pop   = (m_obuf.size() > 0) && out_ready;
            rdpri = (m_ram.size() > 0) && (occ == 0);
            e_ir  = (m_ram.size() < DEPTH) && !rdpri;
            push  = in_valid && e_ir;
            rd    = !push && (m_ram.size() > 0) && ((occ - int'(pop)) < 2);

            chk("in_ready", in_ready, e_ir);
            chk("ram_we", ram_we, push);
            chk("ram_addr", ram_addr, push ? m_wp : m_rp);
            chk("ram_din", ram_din, in_data);
            chk("count", count, m_ram.size() + occ);
            chk("out_valid", out_valid, m_obuf.size() > 0);
            if (m_obuf.size() > 0) chk("out_data", out_data, m_obuf[0]);

            if (out_valid && out_ready) got.push_back(int'(out_data));

            if (pop) void'(m_obuf.pop_front());
            if (m_inf) m_obuf.push_back(m_inf_data);
            m_inf = 0;
            if (push) begin
                m_ram.push_back(int'(in_data));
                m_wp = (m_wp + 1) % DEPTH;
            end
            if (rd) begin
                m_inf      = 1;
                m_inf_data = m_ram.pop_front();
                m_rp       = (m_rp + 1) % DEPTH;
            end
        end
    end

    // Drive one cycle per iteration; push words base.. until n accepted
    task automatic run_stream(input int n, input int base, input int vpct,
                              input int rpct, input int cycles, output int accepted);
        int idx = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            in_valid  = (idx < n) && (int'($urandom_range(99)) < vpct);
            in_data   = DW'(base + idx);
            out_ready = (int'($urandom_range(99)) < rpct);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
        end
        accepted = idx;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int bad;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef SPRAM_FIFO_WATERMARK_EN
        wm_clr    = 1'b0;
`endif
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_count", count, 0);
        chk("init_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single word latency
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        @(negedge clk);
        chk("t1_we_N", ram_we, 1);
        chk("t1_addr_N", ram_addr, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_we_N1", ram_we, 0);
        chk("t1_addr_N1", ram_addr, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_valid_N2", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_valid_N3", out_valid, 1);
        chk("t1_data_N3", out_data, 8'hA5);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t1_count_after", count, 0);

        // Fill with consumer stalled: 8 in RAM + 2 in output buffer
        do_reset();
        got.delete();
        run_stream(13, 0, 100, 0, 30, acc);
        chk("t2_accepted", acc, 10);
        chk("t2_in_ready", in_ready, 0);
        chk("t2_count", count, 10);

        // Drain from full
        run_stream(0, 0, 0, 100, 40, acc);
        chk("t3_n_out", got.size(), 10);
        bad = -1;
        for (int i = 0; i < got.size() && i < 10; i++)
            if (got[i] != i && bad < 0) bad = i;
        chk("t3_order_first_bad", bad, -1);
        chk("t3_count", count, 0);

        // Random traffic across several pointer wraps
        do_reset();
        got.delete();
        run_stream(40, 'h40, 60, 50, 400, acc);
        chk("t4_accepted", acc, 40);
        run_stream(0, 0, 0, 100, 40, acc);
        chk("t4_n_out", got.size(), 40);
        bad = -1;
        for (int i = 0; i < got.size() && i < 40; i++)
            if (got[i] != 'h40 + i && bad < 0) bad = i;
        chk("t4_order_first_bad", bad, -1);

        // Reset with data queued and a read in flight
        do_reset();
        run_stream(5, 'h20, 100, 0, 6, acc);
        chk("t5_accepted", acc, 5);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (m_inf) break;
        end
        chk("t5_inflight_seen", m_inf, 1);
        chk("t5_count_pre", count, 5);
        rst = 1'b1;
        #1;
        chk("t5_valid_rst", out_valid, 0);
        chk("t5_count_rst", count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        got.delete();
        run_stream(1, 'h3C, 100, 100, 12, acc);
        chk("t5_n_out", got.size(), 1);
        chk("t5_first", got.size() > 0 ? got[0] : -1, 'h3C);

`ifdef SPRAM_FIFO_WATERMARK_EN
        // Peak tracking and clear
        do_reset();
        run_stream(6, 'h70, 100, 0, 12, acc);
        chk("t6_count_full", count, 6);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (count == 2) begin
                out_ready = 1'b0;
                break;
            end
            out_ready = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("t6_count_drained", count, 2);
        chk("t6_max_peak", max_count, 6);
        wm_clr = 1'b1;
        @(posedge clk); #1;
        wm_clr = 1'b0;
        chk("t6_max_clr", max_count, 2);
`endif

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
